// File: rtl/isa_mem_bridge.sv
// isa_mem_bridge: converts ARM external-bus chip-select cycles into ISA
// memory read/write cycles (two-phase address latch, BALE, MEMR#/MEMW#,
// IOCHRDY wait extension, transceiver control and ARM wait).
// All ISA timing advances on a clock-enable tick, one every TICK_DIV clks.
// Optional macro ISA_TIMEOUT_EN: bounds the IOCHRDY wait to TIMEOUT_TICKS
// ticks and raises a sticky timeout_err flag.
module isa_mem_bridge #(
    parameter int ARM_ADDR_W    = 12,
    parameter int ISA_ADDR_W    = 24,
    parameter int ISA_DATA_W    = 8,
    parameter int TICK_DIV      = 4,
    parameter int CMD_TICKS     = 3,
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm_cs_n,
    input  logic                  arm_rd_n,
    input  logic                  arm_wr_n,
    input  logic                  addr_sel,
    input  logic [ARM_ADDR_W-1:0] arm_addr,
    input  logic [15:0]           arm_wdata,
    output logic [15:0]           arm_rdata,
    output logic                  arm_wait_n,
    output logic [ISA_ADDR_W-1:0] isa_addr,
    output logic [ISA_DATA_W-1:0] isa_dout,
    input  logic [ISA_DATA_W-1:0] isa_din,
    output logic                  isa_doe,
    output logic                  isa_bale,
    output logic                  isa_memr_n,
    output logic                  isa_memw_n,
    output logic                  isa_sbhe_n,
    input  logic                  isa_iochrdy,
    output logic                  xcvr_oe_n,
    output logic                  xcvr_dir,
    input  logic                  err_clr,
    output logic                  timeout_err
);

    localparam int HI_W = ISA_ADDR_W - ARM_ADDR_W;
    localparam int TK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
    localparam int CC_W = $clog2(CMD_TICKS + 1);
    localparam logic [CC_W-1:0] CC_LAST = CC_W'(CMD_TICKS - 1);
    // Byte-high enable is only driven active on a 16-bit data path
    localparam logic SBHE_ACT = (ISA_DATA_W == 16) ? 1'b0 : 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_SETUP, S_CMD, S_HOLD, S_DONE
    } state_t;

    state_t                  state_q;
    logic [1:0]              cs_sq, rd_sq, wr_sq, rdy_sq;
    logic                    cs_n_s, rd_n_s, wr_n_s, rdy_s;
    logic [TK_W-1:0]         tick_cnt_q;
    logic                    tick;
    logic [ISA_ADDR_W-1:0]   addr_q;
    logic [CC_W-1:0]         cmd_cnt_q;
    logic                    bale_q, memr_n_q, memw_n_q, sbhe_n_q, doe_q;
    logic                    wait_n_q, oe_n_q, dir_q, is_wr_q;
    logic [ISA_DATA_W-1:0]   dout_q;
    logic [15:0]             rdata_q;
    logic [15:0]             rd_word;
    logic [ISA_DATA_W-1:0]   wr_word;
    logic                    start;
    logic                    to_hit;

    // Two-flop synchronisers for the asynchronous ARM strobes and IOCHRDY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sq  <= 2'b11;
            rd_sq  <= 2'b11;
            wr_sq  <= 2'b11;
            rdy_sq <= 2'b11;
        end else begin
            cs_sq  <= {cs_sq[0], arm_cs_n};
            rd_sq  <= {rd_sq[0], arm_rd_n};
            wr_sq  <= {wr_sq[0], arm_wr_n};
            rdy_sq <= {rdy_sq[0], isa_iochrdy};
        end
    end

    assign cs_n_s = cs_sq[1];
    assign rd_n_s = rd_sq[1];
    assign wr_n_s = wr_sq[1];
    assign rdy_s  = rdy_sq[1];

    // Exactly one of rd/wr low qualifies; both low is ignored as illegal
    assign start = !cs_n_s && (rd_n_s ^ wr_n_s);

    // Free-running ISA tick divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt_q <= '0;
        else        tick_cnt_q <= (tick_cnt_q == TK_LAST) ? '0 : tick_cnt_q + 1'b1;
    end

    assign tick = (tick_cnt_q == TK_LAST);

    // Two-phase address latch, open only between bus cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '1;
        end else if (state_q == S_IDLE || state_q == S_DONE) begin
            if (addr_sel) addr_q[ARM_ADDR_W-1:0]          <= arm_addr;
            else          addr_q[ISA_ADDR_W-1:ARM_ADDR_W] <= arm_addr[HI_W-1:0];
        end
    end

    generate
        if (ISA_DATA_W == 16) begin : g_w16
            assign rd_word = isa_din;
            assign wr_word = arm_wdata;
        end else begin : g_w8
            // 8-bit path: the ARM sees the byte in its high lane
            logic unused_wdata_lo;
            assign unused_wdata_lo = ^arm_wdata[7:0];
            assign rd_word = {isa_din, 8'hFF};
            assign wr_word = arm_wdata[15:8];
        end
    endgenerate

`ifdef ISA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    // Current tick is the TIMEOUT_TICKS-th one spent waiting on IOCHRDY
    assign to_hit      = !rdy_s && (to_cnt_q == TO_LAST);
    assign timeout_err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign to_hit         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // Cycle sequencer with registered ISA/ARM control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bale_q    <= 1'b0;
            memr_n_q  <= 1'b1;
            memw_n_q  <= 1'b1;
            sbhe_n_q  <= 1'b1;
            doe_q     <= 1'b0;
            dout_q    <= '0;
            wait_n_q  <= 1'b1;
            rdata_q   <= '1;
            oe_n_q    <= 1'b1;
            dir_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            cmd_cnt_q <= '0;
`ifdef ISA_TIMEOUT_EN
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
`ifdef ISA_TIMEOUT_EN
            // A set later in this block overrides a same-clk clear
            if (err_clr) err_q <= 1'b0;
`endif
            if (cs_n_s && state_q != S_IDLE && state_q != S_DONE) begin
                // ARM dropped chip select mid-cycle: abandon without a capture
                state_q  <= S_IDLE;
                bale_q   <= 1'b0;
                memr_n_q <= 1'b1;
                memw_n_q <= 1'b1;
                sbhe_n_q <= 1'b1;
                doe_q    <= 1'b0;
                wait_n_q <= 1'b1;
                oe_n_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Stall the ARM at once; the ISA cycle waits for a tick
                        wait_n_q <= !start;
                        if (start && tick) begin
                            state_q  <= S_ADDR;
                            bale_q   <= 1'b1;
                            is_wr_q  <= !wr_n_s;
                            doe_q    <= !wr_n_s;
                            dir_q    <= !wr_n_s;
                            oe_n_q   <= 1'b0;
                            sbhe_n_q <= SBHE_ACT;
                            if (!wr_n_s) dout_q <= wr_word;
                        end
                    end
                    S_ADDR: if (tick) begin
                        state_q <= S_SETUP;
                        bale_q  <= 1'b0;
                    end
                    S_SETUP: if (tick) begin
                        state_q   <= S_CMD;
                        memr_n_q  <= is_wr_q;
                        memw_n_q  <= !is_wr_q;
                        cmd_cnt_q <= '0;
`ifdef ISA_TIMEOUT_EN
                        to_cnt_q  <= '0;
`endif
                    end
                    S_CMD: if (tick) begin
                        if (cmd_cnt_q == CC_LAST && (rdy_s || to_hit)) begin
                            state_q  <= S_HOLD;
                            memr_n_q <= 1'b1;
                            memw_n_q <= 1'b1;
                            if (!is_wr_q) rdata_q <= to_hit ? 16'hFFFF : rd_word;
`ifdef ISA_TIMEOUT_EN
                            if (to_hit) err_q <= 1'b1;
`endif
                        end else begin
                            if (cmd_cnt_q != CC_LAST) cmd_cnt_q <= cmd_cnt_q + 1'b1;
`ifdef ISA_TIMEOUT_EN
                            if (!rdy_s && to_cnt_q != TO_LAST) to_cnt_q <= to_cnt_q + 1'b1;
`endif
                        end
                    end
                    S_HOLD: if (tick) begin
                        state_q  <= S_DONE;
                        wait_n_q <= 1'b1;
                        doe_q    <= 1'b0;
                        sbhe_n_q <= 1'b1;
                    end
                    S_DONE: if (cs_n_s) begin
                        state_q <= S_IDLE;
                        oe_n_q  <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign isa_addr   = cs_n_s ? '1 : addr_q;
    assign isa_dout   = dout_q;
    assign isa_doe    = doe_q;
    assign isa_bale   = bale_q;
    assign isa_memr_n = memr_n_q;
    assign isa_memw_n = memw_n_q;
    assign isa_sbhe_n = sbhe_n_q;
    assign arm_wait_n = wait_n_q;
    assign arm_rdata  = rdata_q;
    assign xcvr_oe_n  = oe_n_q;
    assign xcvr_dir   = dir_q;

endmodule

// File: tb/tb_isa_mem_bridge.sv
// Bench for isa_mem_bridge: an 8-bit instance (defaults) and a 16-bit
// instance (TIMEOUT_TICKS=8) share the ARM-side stimulus. Table of full
// bus cycles plus hand sequences for wait extension, timeout, abort,
// illegal strobes and asynchronous reset.
module tb_isa_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, addr_sel = 1'b1, err_clr = 1'b0;
    logic [11:0] arm_addr = '0;
    logic [15:0] wdata = '0;
    logic [7:0]  din8 = '0;
    logic [15:0] din16 = '0;
    logic        rdy8 = 1'b1, rdy16 = 1'b1;

    logic [15:0] rdata8, rdata16;
    logic [23:0] addr8, addr16;
    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic wait8, doe8, bale8, memr8, memw8, sbhe8, oe8, dir8, err8;
    logic wait16, doe16, bale16, memr16, memw16, sbhe16, oe16, dir16, err16;

    always #10 clk = ~clk;

    isa_mem_bridge u8 (
        .clk(clk), .rst_n(rst_n), .arm_cs_n(cs_n), .arm_rd_n(rd_n), .arm_wr_n(wr_n),
        .addr_sel(addr_sel), .arm_addr(arm_addr), .arm_wdata(wdata), .arm_rdata(rdata8),
        .arm_wait_n(wait8), .isa_addr(addr8), .isa_dout(dout8), .isa_din(din8),
        .isa_doe(doe8), .isa_bale(bale8), .isa_memr_n(memr8), .isa_memw_n(memw8),
        .isa_sbhe_n(sbhe8), .isa_iochrdy(rdy8), .xcvr_oe_n(oe8), .xcvr_dir(dir8),
        .err_clr(err_clr), .timeout_err(err8)
    );

    isa_mem_bridge #(.ISA_DATA_W(16), .TIMEOUT_TICKS(8)) u16 (
        .clk(clk), .rst_n(rst_n), .arm_cs_n(cs_n), .arm_rd_n(rd_n), .arm_wr_n(wr_n),
        .addr_sel(addr_sel), .arm_addr(arm_addr), .arm_wdata(wdata), .arm_rdata(rdata16),
        .arm_wait_n(wait16), .isa_addr(addr16), .isa_dout(dout16), .isa_din(din16),
        .isa_doe(doe16), .isa_bale(bale16), .isa_memr_n(memr16), .isa_memw_n(memw16),
        .isa_sbhe_n(sbhe16), .isa_iochrdy(rdy16), .xcvr_oe_n(oe16), .xcvr_dir(dir16),
        .err_clr(err_clr), .timeout_err(err16)
    );

    // Cumulative per-clk activity counters and values captured mid-cycle
    int c_memw8 = 0, c_memr8 = 0, c_bale8 = 0, c_wait8 = 0, c_doe8 = 0, c_sbhe8 = 0;
    int c_memr16 = 0, c_sbhe16 = 0;
    logic [23:0] cap_addr8 = '0, cap_addr16 = '0;
    logic [7:0]  cap_dout8 = '0;
    logic [15:0] cap_dout16 = '0;
    logic        cap_dir8 = 1'b0;

    always @(negedge clk) begin
        if (!memw8)  c_memw8  <= c_memw8 + 1;
        if (!memr8)  c_memr8  <= c_memr8 + 1;
        if (bale8)   c_bale8  <= c_bale8 + 1;
        if (!wait8)  c_wait8  <= c_wait8 + 1;
        if (doe8)    c_doe8   <= c_doe8 + 1;
        if (!sbhe8)  c_sbhe8  <= c_sbhe8 + 1;
        if (!memr16) c_memr16 <= c_memr16 + 1;
        if (!sbhe16) c_sbhe16 <= c_sbhe16 + 1;
        if (bale8)  begin cap_addr8 <= addr8; cap_dir8 <= dir8; end
        if (bale16) cap_addr16 <= addr16;
        if (!memw8)  cap_dout8  <= dout8;
        if (!memw16) cap_dout16 <= dout16;
    end

    int s_memw8, s_memr8, s_bale8, s_wait8, s_doe8, s_sbhe8, s_memr16, s_sbhe16;
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic snap();
        s_memw8 = c_memw8;  s_memr8 = c_memr8;  s_bale8 = c_bale8;  s_wait8 = c_wait8;
        s_doe8 = c_doe8;    s_sbhe8 = c_sbhe8;  s_memr16 = c_memr16; s_sbhe16 = c_sbhe16;
    endtask

    task automatic load_addr(input logic [11:0] lo, input logic [11:0] hi);
        @(negedge clk); addr_sel = 1'b1; arm_addr = lo;
        repeat (2) @(negedge clk);
        addr_sel = 1'b0; arm_addr = hi;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_cycle(input logic wr);
        @(negedge clk);
        cs_n = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    endtask

    task automatic end_cycle();
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    // Wait for the ARM stall to appear and then clear on u8 (and u16 if both)
    task automatic wait_done(input string name, input logic both, input int budget);
        int n;
        n = 0;
        while (wait8 && n < 20) begin @(negedge clk); n++; end
        check({name, " stall"}, 32'(!wait8 || n > 0), 32'd1);
        n = 0;
        while ((!wait8 || (both && !wait16)) && n < budget) begin @(negedge clk); n++; end
        check({name, " done"}, 32'(wait8 && (!both || wait16)), 32'd1);
    endtask

    task automatic wait_memr8_low(input string name);
        int n;
        n = 0;
        while (memr8 && n < 60) begin @(negedge clk); n++; end
        check({name, " memr low"}, 32'(memr8), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] lo, hi;
        logic [15:0] wd;
        logic [7:0]  d8;
        logic [15:0] d16;
        logic [23:0] e_addr;
        logic [7:0]  e_dout8;
        logic [15:0] e_dout16, e_rd8, e_rd16;
        int          e_cmd;
    } vec_t;

    vec_t tv[4];

    initial begin
        int d;
        tv[0] = '{1'b1, 12'h345, 12'h0AB, 16'hC300, 8'h00, 16'h0000, 24'h0AB345, 8'hC3, 16'hC300, 16'hFFFF, 16'hFFFF, 12};
        tv[1] = '{1'b0, 12'h345, 12'h0AB, 16'h0000, 8'h5A, 16'hBEEF, 24'h0AB345, 8'h00, 16'h0000, 16'h5AFF, 16'hBEEF, 12};
        tv[2] = '{1'b1, 12'hFFF, 12'h000, 16'h1234, 8'h00, 16'h0000, 24'h000FFF, 8'h12, 16'h1234, 16'h5AFF, 16'hBEEF, 12};
        tv[3] = '{1'b0, 12'h000, 12'hFFF, 16'h0000, 8'h00, 16'h0001, 24'hFFF000, 8'h00, 16'h0000, 16'h00FF, 16'h0001, 12};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst isa_addr", 32'(addr8), 32'hFFFFFF);
        check("rst ctrl", 32'({doe8, bale8, memr8, memw8, sbhe8, wait8, oe8, dir8, err8}), 32'b001111100);
        check("rst dout/rdata", 32'({dout8, rdata8}), 32'h00FFFF);
        check("rst u16", 32'({dout16 == 16'h0, rdata16 == 16'hFFFF, sbhe16, oe16}), 32'b1111);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table of complete bus cycles
        for (int i = 0; i < 4; i++) begin
            load_addr(tv[i].lo, tv[i].hi);
            wdata = tv[i].wd; din8 = tv[i].d8; din16 = tv[i].d16;
            snap();
            start_cycle(tv[i].wr);
            wait_done($sformatf("v%0d", i), 1'b1, 200);
            check($sformatf("v%0d isa_addr8", i), 32'(cap_addr8), 32'(tv[i].e_addr));
            check($sformatf("v%0d isa_addr16", i), 32'(cap_addr16), 32'(tv[i].e_addr));
            check($sformatf("v%0d bale clks", i), 32'(c_bale8 - s_bale8), 32'd4);
            check($sformatf("v%0d memw clks", i), 32'(c_memw8 - s_memw8), tv[i].wr ? 32'(tv[i].e_cmd) : 32'd0);
            check($sformatf("v%0d memr clks", i), 32'(c_memr8 - s_memr8), tv[i].wr ? 32'd0 : 32'(tv[i].e_cmd));
            d = c_wait8 - s_wait8;
            check($sformatf("v%0d wait clks %0d", i, d), 32'(d >= 24 && d <= 27), 32'd1);
            check($sformatf("v%0d doe clks", i), 32'(c_doe8 - s_doe8), tv[i].wr ? 32'd24 : 32'd0);
            check($sformatf("v%0d sbhe16 clks", i), 32'(c_sbhe16 - s_sbhe16), 32'd24);
            check($sformatf("v%0d sbhe8 clks", i), 32'(c_sbhe8 - s_sbhe8), 32'd0);
            check($sformatf("v%0d dir", i), 32'({cap_dir8, dir8}), tv[i].wr ? 32'b11 : 32'b00);
            check($sformatf("v%0d oe in done", i), 32'({oe8, oe16}), 32'b00);
            if (tv[i].wr) begin
                check($sformatf("v%0d dout8", i), 32'(cap_dout8), 32'(tv[i].e_dout8));
                check($sformatf("v%0d dout16", i), 32'(cap_dout16), 32'(tv[i].e_dout16));
            end
            check($sformatf("v%0d rdata8", i), 32'(rdata8), 32'(tv[i].e_rd8));
            check($sformatf("v%0d rdata16", i), 32'(rdata16), 32'(tv[i].e_rd16));
            end_cycle();
            repeat (4) @(negedge clk);
            check($sformatf("v%0d idle", i), 32'({oe8, addr8}), 32'h1FFFFFF);
        end

        // IOCHRDY low: released in time for the 10th command tick
        load_addr(12'h111, 12'h022);
        din8 = 8'h3C; din16 = 16'h5555; rdy8 = 1'b0;
        snap();
        start_cycle(1'b0);
        wait_memr8_low("rdy");
        repeat (37) @(negedge clk);
        rdy8 = 1'b1;
        wait_done("rdy", 1'b1, 200);
        check("rdy memr8 clks", 32'(c_memr8 - s_memr8), 32'd40);
        check("rdy memr16 clks", 32'(c_memr16 - s_memr16), 32'd12);
        check("rdy rdata", 32'({rdata8, rdata16}), 32'h3CFF5555);
        end_cycle();
        repeat (4) @(negedge clk);

        // IOCHRDY stuck low on the 16-bit instance
        din8 = 8'h77; din16 = 16'hABCD; rdy16 = 1'b0;
        snap();
        start_cycle(1'b0);
`ifdef ISA_TIMEOUT_EN
        wait_done("to", 1'b1, 400);
        check("to memr16 clks", 32'(c_memr16 - s_memr16), 32'd32);
        check("to err", 32'({err16, err8}), 32'b10);
        check("to rdata", 32'({rdata8, rdata16}), 32'h77FFFFFF);
        end_cycle();
        repeat (4) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("to err_clr", 32'(err16), 32'd0);
`else
        wait_done("to", 1'b0, 200);
        repeat (40) @(negedge clk);
        check("to still waiting", 32'({memr16, wait16, err16}), 32'b000);
        end_cycle();
        d = 0;
        while (!memr16 && d < 10) begin @(negedge clk); d++; end
        check("to abort clks", 32'(d), 32'd3);
        check("to abort state", 32'({wait16, oe16, doe16}), 32'b110);
        check("to rdata kept", 32'({rdata8, rdata16}), 32'h77FF5555);
        repeat (4) @(negedge clk);
`endif
        rdy16 = 1'b1;

        // Chip select dropped during the command phase
        din8 = 8'h99; din16 = 16'h9999;
        start_cycle(1'b0);
        wait_memr8_low("abort");
        repeat (2) @(negedge clk);
        end_cycle();
        d = 0;
        while (!memr8 && d < 10) begin @(negedge clk); d++; end
        check("abort clks", 32'(d), 32'd3);
        check("abort ctrl", 32'({memr16, wait8, oe8, doe8, bale8}), 32'b11100);
        check("abort rdata", 32'(rdata8), 32'h77FF);
        repeat (4) @(negedge clk);

        // Both strobes low: illegal, no cycle and no stall
        snap();
        @(negedge clk);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        repeat (24) @(negedge clk);
        check("illegal", 32'({c_wait8 - s_wait8, c_bale8 - s_bale8}), 32'd0);
        check("illegal oe", 32'(oe8), 32'd1);
        end_cycle();
        repeat (4) @(negedge clk);

        // Asynchronous reset in the middle of a write
        load_addr(12'h456, 12'h078);
        wdata = 16'hA5A5;
        start_cycle(1'b1);
        d = 0;
        while (memw8 && d < 60) begin @(negedge clk); d++; end
        check("mrst memw low", 32'(memw8), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mrst ctrl", 32'({memw8, doe8, wait8, oe8, sbhe16, doe16}), 32'b101110);
        check("mrst data", 32'({addr8, dout8}), 32'hFFFFFF00);
        check("mrst rdata", 32'(rdata8), 32'hFFFF);
        end_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
